// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the two-requester sequential multiplier.
package mul_seq_pkg;

    localparam int MUL_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// whichever requester was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic [0:0] last,
    input  logic       enable,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: default first so no path leaves gnt unassigned (no latch).
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last[0] ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mul_seq_arb.sv
// Shift-add multiplier shared by two requesters: one operand pair at a time,
// one multiplier bit per cycle, result held until the consumer takes it.
module mul_seq_arb
    import mul_seq_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*W-1:0]   res_data,
    output logic             res_id,
    output logic             busy
);

    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, b_q;
    logic [2*W-1:0]   acc_q, acc_d, partial;
    logic [2*W-1:0]   res_data_q;
    logic [CW-1:0]    cnt_q;
    logic             id_q, res_id_q, last_q;
    logic [1:0]       gnt;
    logic             arb_en, accept, last_step, res_fire;

    rr_arb2 u_arb (
        .req    (req_valid),
        .last   (last_q),
        .enable (arb_en),
        .gnt    (gnt)
    );

    assign accept    = |gnt;
    assign last_step = (state_q == BUSY) && (cnt_q == LAST_BIT);
    assign res_fire  = (state_q == DONE) && res_ready;

    assign partial = b_q[cnt_q] ? ({{W{1'b0}}, a_q} << cnt_q) : '0;
    assign acc_d   = acc_q + partial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (res_fire)  state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Arbiter is gated by rst_n so no grant is shown while reset is held.
    always_comb begin
        arb_en    = (state_q == IDLE) && rst_n;
        req_ready = gnt;
        busy      = (state_q != IDLE);
        res_valid = (state_q == DONE);
        res_data  = res_data_q;
        res_id    = res_id_q;
    end

    // last_q resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            a_q    <= gnt[1] ? a1 : a0;
            b_q    <= gnt[1] ? b1 : b0;
            id_q   <= gnt[1];
            last_q <= gnt[1];
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (state_q == BUSY) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
            if (last_step) begin
                res_data_q <= acc_d;
                res_id_q   <= id_q;
            end
        end
    end

endmodule

// File: doc/mul_seq_arb.md
MUL_SEQ_ARB -- requirements
Module: mul_seq_arb

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits (W >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 SHALL have port req_ready  output  2  per-requester accept, at most one bit high.
REQ-006 SHALL have ports a0, b0  input  W each  requester 0 multiplicand and multiplier.
REQ-007 SHALL have ports a1, b1  input  W each  requester 1 multiplicand and multiplier.
REQ-008 SHALL have port res_valid  output  1  result available.
REQ-009 SHALL have port res_ready  input  1  consumer accepts result.
REQ-010 SHALL have port res_data  output  2W  unsigned product.
REQ-011 SHALL have port res_id  output  1  index of the requester that owns res_data.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL share one shift-add multiply datapath between two requesters; states IDLE, BUSY, DONE.
REQ-014 In IDLE, req_ready SHALL be a combinational grant: single requester valid -> that requester; both valid -> requester != last_grant; none -> 2'b00.
REQ-015 Acceptance SHALL occur on an edge where req_valid[i] and req_ready[i] are both high; it captures a_i, b_i and i, clears the accumulator and the bit counter, sets last_grant = i, and moves to BUSY.
REQ-016 Operand changes after acceptance SHALL be ignored.
REQ-017 req_ready SHALL be 2'b00 in BUSY and DONE; a request held there SHALL wait, not be dropped.
REQ-018 BUSY SHALL process one multiplier bit per cycle, LSB first: acc = acc + (b[k] ? a << k : 0), for k = 0..W-1.
REQ-019 BUSY SHALL last exactly W cycles regardless of operand values, with no early termination.
REQ-020 res_valid SHALL rise exactly W cycles after the acceptance edge; state moves to DONE on that edge.
REQ-021 Arithmetic SHALL be unsigned and 2W bits wide; the result is exact, with no overflow or truncation.
REQ-022 In DONE, res_valid = 1, and res_data and res_id SHALL be held stable until res_valid && res_ready.
REQ-023 The handshake edge in DONE SHALL return the block to IDLE; no new request is accepted on that edge, and the earliest next acceptance is the following edge.
REQ-024 res_ready SHALL be ignored outside DONE.
REQ-025 res_valid SHALL be 0 in IDLE and BUSY; res_data and res_id SHALL retain their last values outside DONE.

Reset
REQ-026 rst_n low SHALL immediately force: state = IDLE, res_valid = 0, res_data = 0, res_id = 0, busy = 0, accumulator and counter = 0, last_grant = 1 (so requester 0 wins the first tie).
REQ-027 Reset asserted during BUSY or DONE SHALL abort the operation; the result is discarded and never presented.
REQ-028 req_ready SHALL be 2'b00 while rst_n is low.

Structure
REQ-029 Package mul_seq_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and the default width constant MUL_W = 8.
REQ-030 The arbitration logic SHALL be a sub-module rr_arb2 (inputs req[1:0], last[0:0], enable; output gnt[1:0], one-hot or zero); the datapath and FSM stay in mul_seq_arb.

Verification
REQ-031 Single request: req_valid = 2'b01, a0 = 8'd13, b0 = 8'd11 -> accept on edge 0; res_valid rises after edge 8; res_data = 16'd143, res_id = 0.
REQ-032 Max operands: a1 = b1 = 8'hFF -> res_data = 16'hFE01, res_id = 1; zero operand a0 = 0, b0 = 8'hFF -> res_data = 0, latency still 8 cycles.
REQ-033 Contention: both valid continuously from reset with res_ready = 1 -> grants alternate 0,1,0,1; each acceptance is 10 cycles after the previous one (1 accept + 8 BUSY + 1 DONE).
REQ-034 Backpressure: res_ready = 0 for 5 cycles in DONE -> res_valid, res_data and res_id are held constant, req_ready = 0 throughout; the result is released on the first res_ready = 1 edge.
REQ-035 Reset mid-BUSY: assert rst_n low at BUSY cycle 4 -> all outputs are 0 immediately; after release with both requesters valid, requester 0 is granted first.
REQ-036 Operand change: a0 changes on the edge after acceptance -> the product uses the captured a0.
